acumulador_pago: RTL and testbench

//  Coin-payment stage that sits directly upstream of the coffee machine control FSM.
//  - Accumulates the coins entered on the 2-bit switch into the registered amount.
//  - Compares the amount against the price of the selected drink.
//  - Asserts pago_ok to the FSM; computes the change (cambio).
//  - On cancel, returns the whole amount as a one-cycle refund pulse.

---
 rtl/acumulador_pago_if.sv | 28 ++
 rtl/acumulador_pago.sv | 114 +++++++++++
 tb/tb_acumulador_pago.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/acumulador_pago_if.sv
// Bus between the coffee machine front end and the payment accumulator.
// master drives selection/coin/cancel/served; slave returns amount, status and refunds.
interface acumulador_pago_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] costo;
    logic             coin_valid;
    logic [1:0]       coin_sel;
    logic             cancelar;
    logic             served;
    logic [WIDTH-1:0] monto;
    logic             pago_ok;
    logic [WIDTH-1:0] cambio;
    logic [WIDTH-1:0] devolucion;
    logic             refund_valid;
    logic             coin_reject;

    modport master (
        output start, costo, coin_valid, coin_sel, cancelar, served,
        input  monto, pago_ok, cambio, devolucion, refund_valid, coin_reject
    );

    modport slave (
        input  start, costo, coin_valid, coin_sel, cancelar, served,
        output monto, pago_ok, cambio, devolucion, refund_valid, coin_reject
    );
endinterface

// File: rtl/acumulador_pago.sv
// Coin accumulator ahead of the coffee machine FSM: collects coins, flags payment,
// computes change and returns the full amount on cancel. All outputs are registered.
module acumulador_pago #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_MONTO = 15
) (
    input  logic              clk,
    input  logic              rst,
    acumulador_pago_if.slave  bus
);
    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCollect = 2'd1;
    localparam logic [1:0] StPaid    = 2'd2;
    localparam logic [1:0] StRefund  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] monto_q, monto_d;
    logic [WIDTH-1:0] costo_q, costo_d;
    logic [WIDTH-1:0] cambio_q, cambio_d;
    logic [WIDTH-1:0] devolucion_q, devolucion_d;
    logic             pago_ok_q, refund_valid_q;
    logic             coin_reject_q, coin_reject_d;
    logic [WIDTH:0]   coin_value;
    logic [WIDTH:0]   suma;
    logic             coin_fits;

    always_comb begin
        case (bus.coin_sel)
            2'b00:   coin_value = (WIDTH+1)'(1);
            2'b01:   coin_value = (WIDTH+1)'(2);
            2'b10:   coin_value = (WIDTH+1)'(5);
            default: coin_value = (WIDTH+1)'(10);
        endcase
    end

    // One extra bit so an overflowing sum is caught by the limit check, never wrapped.
    assign suma      = {1'b0, monto_q} + coin_value;
    assign coin_fits = (suma <= (WIDTH+1)'(MAX_MONTO));

    always_comb begin
        state_d       = state_q;
        monto_d       = monto_q;
        costo_d       = costo_q;
        coin_reject_d = bus.coin_valid;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    costo_d = bus.costo;
                    monto_d = '0;
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (bus.cancelar) begin
                    state_d = StRefund;
                end else begin
                    if (bus.coin_valid && coin_fits) begin
                        monto_d       = suma[WIDTH-1:0];
                        coin_reject_d = 1'b0;
                    end
                    // Threshold uses the registered amount; a coin on this edge becomes change.
                    if (monto_q >= costo_q) begin
                        state_d = StPaid;
                    end
                end
            end
            StPaid: begin
                if (bus.served) begin
                    state_d = StIdle;
                    monto_d = '0;
                    costo_d = '0;
                end else if (bus.cancelar) begin
                    state_d = StRefund;
                end
            end
            StRefund: begin
                state_d = StIdle;
                monto_d = '0;
                costo_d = '0;
            end
        endcase
        cambio_d     = (state_d == StPaid)   ? (monto_d - costo_d) : '0;
        devolucion_d = (state_d == StRefund) ? monto_d : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            monto_q        <= '0;
            costo_q        <= '0;
            cambio_q       <= '0;
            devolucion_q   <= '0;
            pago_ok_q      <= 1'b0;
            refund_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            monto_q        <= monto_d;
            costo_q        <= costo_d;
            cambio_q       <= cambio_d;
            devolucion_q   <= devolucion_d;
            pago_ok_q      <= (state_d == StPaid);
            refund_valid_q <= (state_d == StRefund);
            coin_reject_q  <= coin_reject_d;
        end
    end

    assign bus.monto        = monto_q;
    assign bus.pago_ok      = pago_ok_q;
    assign bus.cambio       = cambio_q;
    assign bus.devolucion   = devolucion_q;
    assign bus.refund_valid = refund_valid_q;
    assign bus.coin_reject  = coin_reject_q;
endmodule

// File: tb/tb_acumulador_pago.sv
// Directed table-driven bench for acumulador_pago plus hand-written reset sequences.
module tb_acumulador_pago;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    acumulador_pago_if #(.WIDTH(4)) bus ();

    acumulador_pago #(
        .WIDTH     (4),
        .MAX_MONTO (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       start;
        logic [3:0] costo;
        logic       coin_valid;
        logic [1:0] coin_sel;
        logic       cancelar;
        logic       served;
        logic [3:0] e_monto;
        logic       e_pago;
        logic [3:0] e_cambio;
        logic [3:0] e_dev;
        logic       e_refund;
        logic       e_reject;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic st, input logic [3:0] c, input logic cv,
                       input logic [1:0] cs, input logic can, input logic srv,
                       input logic [3:0] m, input logic p, input logic [3:0] cb,
                       input logic [3:0] d, input logic rv, input logic rj);
        vec_t v;
        v.name = n; v.start = st; v.costo = c; v.coin_valid = cv; v.coin_sel = cs;
        v.cancelar = can; v.served = srv; v.e_monto = m; v.e_pago = p; v.e_cambio = cb;
        v.e_dev = d; v.e_refund = rv; v.e_reject = rj;
        vecs.push_back(v);
    endtask

    task automatic check_out(input string n, input logic [3:0] m, input logic p,
                             input logic [3:0] cb, input logic [3:0] d, input logic rv,
                             input logic rj);
        checks++;
        if (bus.monto !== m || bus.pago_ok !== p || bus.cambio !== cb ||
            bus.devolucion !== d || bus.refund_valid !== rv || bus.coin_reject !== rj) begin
            failures++;
            $display("FAIL %s: got monto=%0d pago_ok=%b cambio=%0d devolucion=%0d refund_valid=%b coin_reject=%b, want monto=%0d pago_ok=%b cambio=%0d devolucion=%0d refund_valid=%b coin_reject=%b",
                     n, bus.monto, bus.pago_ok, bus.cambio, bus.devolucion, bus.refund_valid,
                     bus.coin_reject, m, p, cb, d, rv, rj);
        end
    endtask

    task automatic drive(input logic st, input logic [3:0] c, input logic cv,
                         input logic [1:0] cs, input logic can, input logic srv);
        bus.start = st; bus.costo = c; bus.coin_valid = cv; bus.coin_sel = cs;
        bus.cancelar = can; bus.served = srv;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.coin_valid = 1'b0; bus.cancelar = 1'b0; bus.served = 1'b0;
        bus.costo = 4'd0; bus.coin_sel = 2'b00;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        drive_idle();

        //   name          st costo cv sel can srv | monto pago cambio dev rv rj
        add("c7_start",    1, 7,  0, 2'b00, 0, 0,   0, 0, 0, 0,  0, 0);
        add("c7_coin5",    0, 0,  1, 2'b10, 0, 0,   5, 0, 0, 0,  0, 0);
        add("c7_coin2",    0, 0,  1, 2'b01, 0, 0,   7, 0, 0, 0,  0, 0);
        add("c7_paid",     0, 0,  0, 2'b00, 0, 0,   7, 1, 0, 0,  0, 0);
        add("c7_served",   0, 0,  0, 2'b00, 0, 1,   0, 0, 0, 0,  0, 0);
        add("c6_start",    1, 6,  0, 2'b00, 0, 0,   0, 0, 0, 0,  0, 0);
        add("c6_coin5a",   0, 0,  1, 2'b10, 0, 0,   5, 0, 0, 0,  0, 0);
        add("c6_coin5b",   0, 0,  1, 2'b10, 0, 0,  10, 0, 0, 0,  0, 0);
        add("c6_paid",     0, 0,  0, 2'b00, 0, 0,  10, 1, 4, 0,  0, 0);
        add("c6_cancel",   0, 0,  0, 2'b00, 1, 0,  10, 0, 0, 10, 1, 0);
        add("c6_idle",     0, 0,  0, 2'b00, 0, 0,   0, 0, 0, 0,  0, 0);
        add("c15_start",   1, 15, 0, 2'b00, 0, 0,   0, 0, 0, 0,  0, 0);
        add("c15_coin10",  0, 0,  1, 2'b11, 0, 0,  10, 0, 0, 0,  0, 0);
        add("c15_ovf",     0, 0,  1, 2'b11, 0, 0,  10, 0, 0, 0,  0, 1);
        add("c15_hold",    0, 0,  0, 2'b00, 0, 0,  10, 0, 0, 0,  0, 0);
        add("c15_cancel",  0, 0,  0, 2'b00, 1, 0,  10, 0, 0, 10, 1, 0);
        add("c15_idle",    0, 0,  0, 2'b00, 0, 0,   0, 0, 0, 0,  0, 0);
        add("c9_start",    1, 9,  0, 2'b00, 0, 0,   0, 0, 0, 0,  0, 0);
        add("c9_coin2",    0, 0,  1, 2'b01, 0, 0,   2, 0, 0, 0,  0, 0);
        add("c9_coin1",    0, 0,  1, 2'b00, 0, 0,   3, 0, 0, 0,  0, 0);
        add("c9_can_coin", 0, 0,  1, 2'b01, 1, 0,   3, 0, 0, 3,  1, 1);
        add("c9_idle",     0, 0,  0, 2'b00, 0, 0,   0, 0, 0, 0,  0, 0);
        add("idle_coin",   0, 0,  1, 2'b10, 0, 0,   0, 0, 0, 0,  0, 1);
        add("c0_start",    1, 0,  0, 2'b00, 0, 0,   0, 0, 0, 0,  0, 0);
        add("c0_paid",     0, 0,  0, 2'b00, 0, 0,   0, 1, 0, 0,  0, 0);
        add("paid_start",  1, 5,  0, 2'b00, 0, 0,   0, 1, 0, 0,  0, 0);
        add("paid_coin",   0, 0,  1, 2'b00, 0, 0,   0, 1, 0, 0,  0, 1);
        add("srv_and_can", 0, 0,  0, 2'b00, 1, 1,   0, 0, 0, 0,  0, 0);
        add("c2_start",    1, 2,  0, 2'b00, 0, 0,   0, 0, 0, 0,  0, 0);
        add("c2_coin2",    0, 0,  1, 2'b01, 0, 0,   2, 0, 0, 0,  0, 0);
        add("c2_late5",    0, 0,  1, 2'b10, 0, 0,   7, 1, 5, 0,  0, 0);
        add("c2_served",   0, 0,  0, 2'b00, 0, 1,   0, 0, 0, 0,  0, 0);
        add("max_start",   1, 15, 0, 2'b00, 0, 0,   0, 0, 0, 0,  0, 0);
        add("max_coin10",  0, 0,  1, 2'b11, 0, 0,  10, 0, 0, 0,  0, 0);
        add("max_coin5",   0, 0,  1, 2'b10, 0, 0,  15, 0, 0, 0,  0, 0);
        add("max_paid",    0, 0,  0, 2'b00, 0, 0,  15, 1, 0, 0,  0, 0);
        add("max_coin1",   0, 0,  1, 2'b00, 0, 0,  15, 1, 0, 0,  0, 1);
        add("max_served",  0, 0,  0, 2'b00, 0, 1,   0, 0, 0, 0,  0, 0);

        #2;
        check_out("reset_state", 0, 0, 0, 0, 0, 0);
        #10 rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].costo, vecs[i].coin_valid, vecs[i].coin_sel,
                  vecs[i].cancelar, vecs[i].served);
            check_out(vecs[i].name, vecs[i].e_monto, vecs[i].e_pago, vecs[i].e_cambio,
                      vecs[i].e_dev, vecs[i].e_refund, vecs[i].e_reject);
        end

        // Asynchronous reset while collecting with monto=7, then prove the FSM is in IDLE.
        drive(1'b1, 4'd9, 1'b0, 2'b00, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 1'b1, 2'b10, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 1'b1, 2'b01, 1'b0, 1'b0);
        check_out("pre_reset_monto7", 7, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        #1 check_out("async_reset", 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        drive(1'b0, 4'd0, 1'b1, 2'b00, 1'b0, 1'b0);
        check_out("post_reset_idle", 0, 0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic drive_idle();
        bus.start = 1'b0; bus.costo = 4'd0; bus.coin_valid = 1'b0; bus.coin_sel = 2'b00;
        bus.cancelar = 1'b0; bus.served = 1'b0;
    endtask
endmodule
